rca_pipe_addsub: RTL and testbench
==================================

Name: rca_pipe_addsub

Overview:
- Parametrised, pipelined ripple-carry adder/subtractor; the sequential successor to the combinational RCA16_BIT datapath.
- Splits a WIDTH-bit operation into STAGES equal chunks. Each pipeline stage ripples one chunk and registers the carry.
- Uses a valid/ready handshake on input and output, with back-pressure and in-order delivery.
- Serves as the arithmetic unit in streaming datapaths where a full-width ripple carry would limit clock rate.

Parameters:
- WIDTH, 16, operand/result width in bits; must be ≥ 2.
- STAGES, 4, number of pipeline stages. Must divide WIDTH; CHUNK = WIDTH/STAGES. STAGES = 1 gives a single registered stage.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- in_valid  input  1  operands present
- in_ready  output  1  block accepts operands this cycle
- a  input  WIDTH  operand A (two's complement or unsigned)
- b  input  WIDTH  operand B
- sub  input  1  0: a+b, 1: a−b
- out_valid  output  1  result present
- out_ready  input  1  downstream accepts result
- sum  output  WIDTH  result
- cout  output  1  carry out of MSB (for sub: 1 = no borrow)
- ovf  output  1  signed overflow

Behaviour:
- Reset and clock: one clock; reset is synchronous and active-low (rst_n sampled on rising clk). Reset dominates all other inputs.
- Reset values: all stage valid bits, out_valid, sum, cout and ovf = 0. in_ready = 1 in the cycle after reset.
- Subtraction: b is XORed bitwise with sub, and carry-in to chunk 0 = sub.
- Per-chunk arithmetic: chunk i computes {c, s} = a_i + b'_i + carry_in_i at CHUNK+1 bits. Only one chunk adder lies between registers.
- Stage contents: stage k holds sum bits for chunks 0..k, the carry out of chunk k, the unprocessed upper slices of a and b', and the sign bits a[MSB], b'[MSB].
- Pipeline enable: en = !out_valid || out_ready. in_ready = en (combinational, no dependency on in_valid).
- Acceptance: an operand is accepted on an edge where in_valid && in_ready. If en = 1 and in_valid = 0, a bubble (valid = 0) enters stage 0.
- Advancement: all stages advance together when en = 1 and hold completely when en = 0. No data is lost or duplicated.
- Latency: the result appears with out_valid = 1 exactly STAGES edges after acceptance, given no stall. Throughput is one result per cycle.
- Output flags: ovf = (a[MSB] == b'[MSB]) && (sum[MSB] != a[MSB]). cout = carry out of the final chunk.
- Output stability: sum, cout and ovf are held stable while out_valid && !out_ready.
- Bubbles: results tagged invalid never raise out_valid. The data fields of invalid stages are don't-care.
- Ordering: results leave in acceptance order.
- Reset mid-operation: all in-flight operations are discarded. out_valid = 0 on the cycle after the reset edge.

Optional Feature:
- Macro: RCA_PIPE_SATURATE_EN.
- When defined: if ovf = 1, sum is clamped to signed max (0x7FF…F) on positive overflow, or signed min (0x800…0) on negative overflow. cout and ovf are reported unchanged.
- When undefined: sum is the wrapped WIDTH-bit result. No clamp logic is synthesised.

Test Plan (WIDTH=16, STAGES=4, out_ready=1 unless stated):
- Basic add: a=0x1234, b=0x0FFF, sub=0 → 4 edges later out_valid=1, sum=0x2233, cout=0, ovf=0.
- Full carry ripple across all chunks: a=0xFFFF, b=0x0001, sub=0 → sum=0x0000, cout=1, ovf=0.
- Subtract with overflow: a=0x8000, b=0x0001, sub=1 → sum=0x7FFF, cout=1, ovf=1. With RCA_PIPE_SATURATE_EN: sum=0x8000.
- Add with overflow: a=0x7FFF, b=0x0001, sub=0 → sum=0x8000, cout=0, ovf=1. With RCA_PIPE_SATURATE_EN: sum=0x7FFF.
- Back-pressure: stream 8 operations (a=i, b=i×0x100, i=0..7); hold out_ready=0 for 6 cycles mid-stream → in_ready=0 while stalled, sum/out_valid held, all 8 results appear in order with correct values.
- Reset mid-flight: accept 3 operations, assert rst_n=0 for one edge → out_valid=0 from the next cycle; no stale result appears afterwards; the next accepted operation produces its correct result after 4 edges.

Source files
------------

// File: rtl/rca_pipe_addsub_if.sv
// rca_pipe_addsub_if
//   Handshake bundle for the pipelined ripple-carry adder/subtractor.
//   Operand side : in_valid, in_ready, a, b, sub
//   Result side  : out_valid, out_ready, sum, cout, ovf
//   master : the block that feeds operands and consumes results
//   slave  : the arithmetic unit itself
interface rca_pipe_addsub_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/rca_pipe_addsub.sv
// rca_pipe_addsub
//   Pipelined ripple-carry adder/subtractor. A WIDTH-bit operation is cut into
//   STAGES chunks of CHUNK = WIDTH/STAGES bits; each stage ripples one chunk
//   and registers its carry, so only one chunk adder sits between registers.
//   Results leave in acceptance order, STAGES edges after the operand is taken.
//
//   Ports:
//     clk   : rising-edge clock
//     rst_n : synchronous active-low reset, dominates everything else
//     bus   : rca_pipe_addsub_if.slave
//             in_valid/in_ready/a/b/sub   operand handshake (sub=1 -> a-b)
//             out_valid/out_ready/sum     result handshake
//             cout (carry out of MSB, 1 = no borrow for sub), ovf (signed)
//
//   Build option:
//     RCA_PIPE_SATURATE_EN : when defined, an overflowing result is clamped to
//     the signed max/min; cout and ovf are reported unchanged.
module rca_pipe_addsub #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  rca_pipe_addsub_if.slave bus
);
  localparam int CHUNK = WIDTH / STAGES;
  localparam int LAST  = STAGES - 1;

  if (WIDTH < 2 || STAGES < 1 || (WIDTH % STAGES) != 0) begin : g_bad_cfg
    $error("rca_pipe_addsub: WIDTH must be >= 2 and divisible by STAGES");
  end

  logic             en;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] last_sum;
  logic             last_ovf;

  // Subtraction is a + ~b + 1: invert b here, the +1 is the carry into chunk 0.
  assign b_eff = bus.b ^ {WIDTH{bus.sub}};

  // The whole pipe moves as one: it advances unless a finished result is
  // waiting on a busy consumer.
  assign en           = !g_stage[LAST].vld_q || bus.out_ready;
  assign bus.in_ready = en;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    // Stage k owns the low SW result bits and the REM operand bits still to add.
    localparam int SW  = (k + 1) * CHUNK;
    localparam int REM = WIDTH - SW;

    logic [CHUNK-1:0] a_chunk;
    logic [CHUNK-1:0] b_chunk;
    logic             c_in;
    logic             v_in;
    logic             a_sign_in;
    logic             b_sign_in;
    logic [SW-1:0]    sum_in;
    logic [CHUNK:0]   chunk_res;

    logic             vld_q;
    logic             carry_q;
    logic             a_sign_q;
    logic             b_sign_q;
    logic [SW-1:0]    sum_q;

    if (k == 0) begin : g_src
      assign a_chunk   = bus.a[CHUNK-1:0];
      assign b_chunk   = b_eff[CHUNK-1:0];
      assign c_in      = bus.sub;
      assign v_in      = bus.in_valid;
      assign a_sign_in = bus.a[WIDTH-1];
      assign b_sign_in = b_eff[WIDTH-1];
      assign sum_in    = chunk_res[CHUNK-1:0];
    end else begin : g_src
      // Operand remainders are kept right-aligned, so the next chunk is
      // always the low CHUNK bits of the previous stage's remainder.
      assign a_chunk   = g_stage[k-1].g_rem.a_rem_q[CHUNK-1:0];
      assign b_chunk   = g_stage[k-1].g_rem.b_rem_q[CHUNK-1:0];
      assign c_in      = g_stage[k-1].carry_q;
      assign v_in      = g_stage[k-1].vld_q;
      assign a_sign_in = g_stage[k-1].a_sign_q;
      assign b_sign_in = g_stage[k-1].b_sign_q;
      assign sum_in    = {chunk_res[CHUNK-1:0], g_stage[k-1].sum_q};
    end

    assign chunk_res = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, c_in};

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        vld_q    <= 1'b0;
        carry_q  <= 1'b0;
        a_sign_q <= 1'b0;
        b_sign_q <= 1'b0;
        sum_q    <= '0;
      end else if (en) begin
        vld_q    <= v_in;
        carry_q  <= chunk_res[CHUNK];
        a_sign_q <= a_sign_in;
        b_sign_q <= b_sign_in;
        sum_q    <= sum_in;
      end
    end

    if (REM > 0) begin : g_rem
      logic [REM-1:0] a_rem_in;
      logic [REM-1:0] b_rem_in;
      logic [REM-1:0] a_rem_q;
      logic [REM-1:0] b_rem_q;

      if (k == 0) begin : g_rsrc
        assign a_rem_in = bus.a[WIDTH-1:CHUNK];
        assign b_rem_in = b_eff[WIDTH-1:CHUNK];
      end else begin : g_rsrc
        assign a_rem_in = g_stage[k-1].g_rem.a_rem_q[REM+CHUNK-1:CHUNK];
        assign b_rem_in = g_stage[k-1].g_rem.b_rem_q[REM+CHUNK-1:CHUNK];
      end

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          a_rem_q <= '0;
          b_rem_q <= '0;
        end else if (en) begin
          a_rem_q <= a_rem_in;
          b_rem_q <= b_rem_in;
        end
      end
    end
  end

  // Signed overflow: operands agree in sign but the result does not.
  assign last_sum      = g_stage[LAST].sum_q;
  assign last_ovf      = (g_stage[LAST].a_sign_q == g_stage[LAST].b_sign_q) &&
                         (last_sum[WIDTH-1] != g_stage[LAST].a_sign_q);
  assign bus.out_valid = g_stage[LAST].vld_q;
  assign bus.cout      = g_stage[LAST].carry_q;
  assign bus.ovf       = last_ovf;

`ifdef RCA_PIPE_SATURATE_EN
  // Overflow direction follows the common operand sign: both negative clamps
  // to signed min, both non-negative clamps to signed max.
  assign bus.sum = !last_ovf ? last_sum :
                   g_stage[LAST].a_sign_q ? {1'b1, {(WIDTH-1){1'b0}}}
                                          : {1'b0, {(WIDTH-1){1'b1}}};
`else
  assign bus.sum = last_sum;
`endif
endmodule

// File: tb/tb_rca_pipe_addsub.sv
// tb_rca_pipe_addsub
//   Self-checking bench for rca_pipe_addsub (WIDTH=16, STAGES=4). Inputs are
//   driven 1 time unit after the rising edge; outputs are sampled on the
//   falling edge. Expected results come from plain integer arithmetic.
module tb_rca_pipe_addsub;
  localparam int WIDTH  = 16;
  localparam int STAGES = 4;

  typedef struct {
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
  } res_t;

  logic clk = 1'b0;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;
  res_t exp_q[$];
  res_t got_q[$];

  rca_pipe_addsub_if #(.WIDTH(WIDTH)) bus ();

  rca_pipe_addsub #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Reference: exact signed/unsigned arithmetic on wide integers.
  function automatic res_t ref_model(input logic [WIDTH-1:0] a,
                                     input logic [WIDTH-1:0] b,
                                     input logic sub);
    res_t   r;
    longint ua, ub, sa, sb, exact, lim;
    ua  = longint'(a);
    ub  = longint'(b);
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    lim = longint'(1) <<< (WIDTH - 1);
    if (sub) begin
      exact  = sa - sb;
      r.cout = (ua >= ub);
      r.sum  = WIDTH'(ua - ub);
    end else begin
      exact  = sa + sb;
      r.cout = ((ua + ub) >>> WIDTH) != 0;
      r.sum  = WIDTH'(ua + ub);
    end
    r.ovf = (exact >= lim) || (exact < -lim);
`ifdef RCA_PIPE_SATURATE_EN
    if (r.ovf) r.sum = (exact > 0) ? WIDTH'(lim - 1) : WIDTH'(lim);
`endif
    return r;
  endfunction

  // Scoreboard feed: accepted operands and delivered results.
  always @(negedge clk) begin
    res_t r;
    if (rst_n !== 1'b1) begin
      exp_q.delete();
    end else begin
      if (bus.in_valid && bus.in_ready) exp_q.push_back(ref_model(bus.a, bus.b, bus.sub));
      if (bus.out_valid && bus.out_ready) begin
        r.sum  = bus.sum;
        r.cout = bus.cout;
        r.ovf  = bus.ovf;
        got_q.push_back(r);
      end
    end
  end

  task automatic test_reset();
    bit seen;
    rst_n = 1'b0;
    bus.in_valid = 1'b1;
    bus.a = 16'h1234;
    bus.b = 16'h4321;
    bus.sub = 1'b0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_out_valid: got %b want 0", bus.out_valid); end
    n_tests++; if (bus.sum !== '0) begin n_fail++; $display("[TB] FAIL reset_sum: got %h want 0000", bus.sum); end
    n_tests++; if (bus.cout !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_cout: got %b want 0", bus.cout); end
    n_tests++; if (bus.ovf !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_ovf: got %b want 0", bus.ovf); end
    n_tests++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_in_ready: got %b want 1", bus.in_ready); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    seen = 0;
    repeat (STAGES + 3) begin
      @(negedge clk);
      if (bus.out_valid !== 1'b0) seen = 1;
    end
    n_tests++; if (seen) begin n_fail++; $display("[TB] FAIL reset_no_result: got out_valid=1 want 0 after reset"); end
  endtask

  task automatic test_directed();
    logic [WIDTH-1:0] va[4], vb[4], vsum[4];
    logic             vsub[4], vcout[4], vovf[4];
    va    = '{16'h1234, 16'hFFFF, 16'h8000, 16'h7FFF};
    vb    = '{16'h0FFF, 16'h0001, 16'h0001, 16'h0001};
    vsub  = '{1'b0, 1'b0, 1'b1, 1'b0};
    vcout = '{1'b0, 1'b1, 1'b1, 1'b0};
    vovf  = '{1'b0, 1'b0, 1'b1, 1'b1};
`ifdef RCA_PIPE_SATURATE_EN
    vsum  = '{16'h2233, 16'h0000, 16'h8000, 16'h7FFF};
`else
    vsum  = '{16'h2233, 16'h0000, 16'h7FFF, 16'h8000};
`endif
    for (int v = 0; v < 4; v++) begin
      int   lat;
      bit   seen;
      res_t r;
      @(posedge clk); #1;
      bus.a = va[v];
      bus.b = vb[v];
      bus.sub = vsub[v];
      bus.in_valid = 1'b1;
      bus.out_ready = 1'b1;
      lat = 0;
      seen = 0;
      while (!seen && lat < 20) begin
        @(posedge clk); #1;
        lat++;
        bus.in_valid = 1'b0;
        @(negedge clk);
        if (bus.out_valid === 1'b1) begin
          seen = 1;
          r.sum = bus.sum;
          r.cout = bus.cout;
          r.ovf = bus.ovf;
        end
      end
      n_tests++;
      if (!seen || lat != STAGES) begin
        n_fail++;
        $display("[TB] FAIL dir%0d_latency: got %0d edges (seen=%0d) want %0d", v, lat, seen, STAGES);
      end else begin
        n_tests++; if (r.sum !== vsum[v]) begin n_fail++; $display("[TB] FAIL dir%0d_sum: got %h want %h", v, r.sum, vsum[v]); end
        n_tests++; if (r.cout !== vcout[v]) begin n_fail++; $display("[TB] FAIL dir%0d_cout: got %b want %b", v, r.cout, vcout[v]); end
        n_tests++; if (r.ovf !== vovf[v]) begin n_fail++; $display("[TB] FAIL dir%0d_ovf: got %b want %b", v, r.ovf, vovf[v]); end
      end
    end
    repeat (2) @(posedge clk);
  endtask

  task automatic test_random(input int n_ops);
    logic [WIDTH-1:0] corner[5];
    int               issued, guard;
    bit               hold, prev_stall;
    res_t             held;
    corner = '{16'h0000, 16'hFFFF, 16'h8000, 16'h7FFF, 16'h0001};
    exp_q.delete();
    got_q.delete();
    issued = 0;
    guard = 0;
    hold = 0;
    prev_stall = 0;
    while (issued < n_ops && guard < 20 * n_ops) begin
      @(posedge clk); #1;
      guard++;
      if (!hold) begin
        bus.in_valid = ($urandom_range(0, 9) < 7);
        bus.a = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : WIDTH'($urandom);
        bus.b = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : WIDTH'($urandom);
        bus.sub = 1'($urandom_range(0, 1));
      end
      bus.out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (prev_stall) begin
        n_tests++;
        if (bus.out_valid !== 1'b1 || bus.sum !== held.sum || bus.cout !== held.cout || bus.ovf !== held.ovf) begin
          n_fail++;
          $display("[TB] FAIL rand_hold: got v=%b %h/%b/%b want v=1 %h/%b/%b",
                   bus.out_valid, bus.sum, bus.cout, bus.ovf, held.sum, held.cout, held.ovf);
        end
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      held.sum = bus.sum;
      held.cout = bus.cout;
      held.ovf = bus.ovf;
      hold = bus.in_valid && !bus.in_ready;
      if (bus.in_valid && bus.in_ready) issued++;
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    repeat (STAGES + 4) @(posedge clk);
    @(negedge clk);
    n_tests++;
    if (exp_q.size() != n_ops || got_q.size() != exp_q.size()) begin
      n_fail++;
      $display("[TB] FAIL rand_count: got %0d results for %0d accepted, want %0d", got_q.size(), exp_q.size(), n_ops);
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_tests++;
      if (got_q[i].sum !== exp_q[i].sum || got_q[i].cout !== exp_q[i].cout || got_q[i].ovf !== exp_q[i].ovf) begin
        n_fail++;
        $display("[TB] FAIL rand_result%0d: got %h/%b/%b want %h/%b/%b", i,
                 got_q[i].sum, got_q[i].cout, got_q[i].ovf, exp_q[i].sum, exp_q[i].cout, exp_q[i].ovf);
      end
    end
  endtask

  task automatic test_back_pressure();
    int               idx, cyc;
    logic [WIDTH-1:0] snap;
    logic [WIDTH-1:0] want;
    got_q.delete();
    idx = 0;
    cyc = 0;
    snap = '0;
    while (idx < 8 && cyc < 100) begin
      @(posedge clk); #1;
      bus.in_valid = 1'b1;
      bus.a = WIDTH'(idx);
      bus.b = WIDTH'(idx * 256);
      bus.sub = 1'b0;
      bus.out_ready = !(cyc >= 5 && cyc < 11);
      @(negedge clk);
      if (cyc >= 5 && cyc < 11) begin
        n_tests++;
        if (bus.in_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL bp_in_ready c%0d: got %b want 0", cyc, bus.in_ready); end
        n_tests++;
        if (bus.out_valid !== 1'b1 || (cyc > 5 && bus.sum !== snap)) begin
          n_fail++;
          $display("[TB] FAIL bp_hold c%0d: got v=%b sum=%h want v=1 sum=%h", cyc, bus.out_valid, bus.sum, snap);
        end
        if (cyc == 5) snap = bus.sum;
      end
      if (bus.in_ready === 1'b1) idx++;
      cyc++;
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    repeat (STAGES + 4) @(posedge clk);
    @(negedge clk);
    n_tests++;
    if (got_q.size() != 8) begin n_fail++; $display("[TB] FAIL bp_count: got %0d want 8", got_q.size()); end
    for (int i = 0; i < 8 && i < got_q.size(); i++) begin
      want = WIDTH'(i + i * 256);
      n_tests++;
      if (got_q[i].sum !== want || got_q[i].cout !== 1'b0 || got_q[i].ovf !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL bp_result%0d: got %h/%b/%b want %h/0/0", i, got_q[i].sum, got_q[i].cout, got_q[i].ovf, want);
      end
    end
  endtask

  task automatic test_reset_midflight();
    bit   stale, seen;
    int   lat;
    res_t want, r;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      bus.in_valid = 1'b1;
      bus.a = WIDTH'($urandom);
      bus.b = WIDTH'($urandom);
      bus.sub = 1'($urandom_range(0, 1));
    end
    @(posedge clk); #1;
    rst_n = 1'b0;
    bus.a = 16'hAAAA;
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL midrst_out_valid: got %b want 0", bus.out_valid); end
    stale = 0;
    repeat (STAGES + 4) begin
      @(negedge clk);
      if (bus.out_valid !== 1'b0) stale = 1;
    end
    n_tests++; if (stale) begin n_fail++; $display("[TB] FAIL midrst_stale: got out_valid=1 want 0 after flush"); end
    @(posedge clk); #1;
    bus.a = 16'h4000;
    bus.b = 16'hC123;
    bus.sub = 1'b1;
    bus.in_valid = 1'b1;
    want = ref_model(bus.a, bus.b, bus.sub);
    lat = 0;
    seen = 0;
    while (!seen && lat < 20) begin
      @(posedge clk); #1;
      lat++;
      bus.in_valid = 1'b0;
      @(negedge clk);
      if (bus.out_valid === 1'b1) begin
        seen = 1;
        r.sum = bus.sum;
        r.cout = bus.cout;
        r.ovf = bus.ovf;
      end
    end
    n_tests++;
    if (!seen || lat != STAGES) begin
      n_fail++;
      $display("[TB] FAIL midrst_latency: got %0d edges (seen=%0d) want %0d", lat, seen, STAGES);
    end else begin
      n_tests++;
      if (r.sum !== want.sum || r.cout !== want.cout || r.ovf !== want.ovf) begin
        n_fail++;
        $display("[TB] FAIL midrst_result: got %h/%b/%b want %h/%b/%b", r.sum, r.cout, r.ovf, want.sum, want.cout, want.ovf);
      end
    end
    repeat (2) @(posedge clk);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random(150);
    test_back_pressure();
    test_reset_midflight();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1, "[TB] watchdog expired");
  end
endmodule
